// File: rtl/pokey_bus_scheduler_if.sv
// Requester-side bundle for pokey_bus_scheduler: host handshake port plus player write-FIFO port.
// The master modport belongs to the requesters; the slave modport belongs to the scheduler.
interface pokey_bus_scheduler_if;
    logic       h_req;
    logic       h_rw;
    logic [3:0] h_addr;
    logic [7:0] h_wdata;
    logic       h_ack;
    logic [7:0] h_rdata;
    logic       p_push;
    logic [3:0] p_addr;
    logic [7:0] p_data;
    logic       p_full;
    logic       p_ovf;

    modport master (
        output h_req, h_rw, h_addr, h_wdata, p_push, p_addr, p_data,
        input  h_ack, h_rdata, p_full, p_ovf
    );

    modport slave (
        input  h_req, h_rw, h_addr, h_wdata, p_push, p_addr, p_data,
        output h_ack, h_rdata, p_full, p_ovf
    );
endinterface

// File: rtl/pokey_bus_scheduler.sv
// Issues host and player register accesses to the POKEY CPU bus, one per phi2 period, aligned to enp.
// Define POKEY_SCHED_RR_EN for round-robin arbitration; otherwise the host has strict priority.
module pokey_bus_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enp_i,
    pokey_bus_scheduler_if.slave        req_if,
    input  logic [7:0]                  bus_din_i,
    output logic [1:0]                  bus_cs_o,
    output logic                        bus_rw_o,
    output logic [3:0]                  bus_a_o,
    output logic [7:0]                  bus_dout_o,
    output logic                        bus_oe_o,
    output logic                        busy_o
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [1:0]      CS_ACTIVE = 2'b10;
    localparam logic [1:0]      CS_IDLE   = 2'b01;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } entry_t;

    state_t          state_q;
    logic            cur_host_q;
    logic [1:0]      bus_cs_q;
    logic            bus_rw_q;
    logic [3:0]      bus_a_q;
    logic [7:0]      bus_dout_q;
    logic            bus_oe_q;
    logic            busy_q;
    logic            h_ack_q;
    logic [7:0]      h_rdata_q;
    entry_t          fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            p_full_q;
    logic            p_ovf_q;
`ifdef POKEY_SCHED_RR_EN
    logic            last_host_q;
`endif

    logic            completing;
    logic            done_host;
    logic            done_player;
    logic            host_pend;
    logic            player_pend;
    logic            pick_host;
    logic            grant;
    logic            push_ok;
    entry_t          head;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        head        = fifo_q[rd_ptr_q];
        player_pend = (count_q != '0);
        completing  = (state_q == ST_ACTIVE) && enp_i;
        done_host   = completing && cur_host_q;
        done_player = completing && !cur_host_q;
        // The host request is still high during its own completion and ack cycles.
        host_pend   = req_if.h_req && !h_ack_q && !done_host;
        if (done_player) begin
            head        = fifo_q[AW'(rd_ptr_q + 1'b1)];
            player_pend = (count_q > CW'(1));
        end
`ifdef POKEY_SCHED_RR_EN
        pick_host   = host_pend && (!player_pend || !last_host_q);
`else
        pick_host   = host_pend;
`endif
        grant       = enp_i && (pick_host || player_pend);
        push_ok     = req_if.p_push && (count_q != FULL_CNT);
        count_d     = count_q + CW'(push_ok) - CW'(done_player);
    end

    // NOTE: the FIFO storage is not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= '{addr: req_if.p_addr, data: req_if.p_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_host_q  <= 1'b0;
            bus_cs_q    <= CS_IDLE;
            bus_rw_q    <= 1'b1;
            bus_a_q     <= '0;
            bus_dout_q  <= '0;
            bus_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            h_ack_q     <= 1'b0;
            h_rdata_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            p_full_q    <= 1'b0;
            p_ovf_q     <= 1'b0;
`ifdef POKEY_SCHED_RR_EN
            last_host_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            h_ack_q  <= done_host;
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_q + AW'(done_player);
            count_q  <= count_d;
            p_full_q <= (count_d == FULL_CNT);
            if (req_if.p_push && !push_ok) begin
                p_ovf_q <= 1'b1;
            end
            if (done_host && bus_rw_q) begin
                h_rdata_q <= bus_din_i;
            end
            if (enp_i) begin
                if (grant) begin
                    state_q    <= ST_ACTIVE;
                    cur_host_q <= pick_host;
                    bus_cs_q   <= CS_ACTIVE;
                    busy_q     <= 1'b1;
`ifdef POKEY_SCHED_RR_EN
                    last_host_q <= pick_host;
`endif
                    if (pick_host) begin
                        bus_rw_q   <= req_if.h_rw;
                        bus_a_q    <= req_if.h_addr;
                        bus_dout_q <= req_if.h_wdata;
                        bus_oe_q   <= !req_if.h_rw;
                    end else begin
                        bus_rw_q   <= 1'b0;
                        bus_a_q    <= head.addr;
                        bus_dout_q <= head.data;
                        bus_oe_q   <= 1'b1;
                    end
                end else begin
                    state_q  <= ST_IDLE;
                    bus_cs_q <= CS_IDLE;
                    bus_rw_q <= 1'b1;
                    bus_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            end
        end
    end

    assign req_if.h_ack   = h_ack_q;
    assign req_if.h_rdata = h_rdata_q;
    assign req_if.p_full  = p_full_q;
    assign req_if.p_ovf   = p_ovf_q;
    assign bus_cs_o       = bus_cs_q;
    assign bus_rw_o       = bus_rw_q;
    assign bus_a_o        = bus_a_q;
    assign bus_dout_o     = bus_dout_q;
    assign bus_oe_o       = bus_oe_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_pokey_bus_scheduler.sv
// Bench for pokey_bus_scheduler: directed host/FIFO/arbitration/reset sequences, then random traffic
// compared against a transaction-level model (player queue plus pending host request).
module tb_pokey_bus_scheduler;

    localparam int DEPTH   = 4;
    localparam int ENP_PER = 8;

    typedef struct {
        logic       rw;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        logic       exp_oe;
        logic [7:0] exp_rdata;
    } host_vec_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       enp     = 1'b0;
    logic [7:0] bus_din = '0;
    logic [1:0] bus_cs;
    logic       bus_rw;
    logic [3:0] bus_a;
    logic [7:0] bus_dout;
    logic       bus_oe;
    logic       busy;

    pokey_bus_scheduler_if rif ();

    pokey_bus_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enp_i      (enp),
        .req_if     (rif),
        .bus_din_i  (bus_din),
        .bus_cs_o   (bus_cs),
        .bus_rw_o   (bus_rw),
        .bus_a_o    (bus_a),
        .bus_dout_o (bus_dout),
        .bus_oe_o   (bus_oe),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int   n_checks   = 0;
    int   n_err      = 0;
    int   phase      = 0;
    int   rearm      = 0;
    bit   enp_en     = 1'b0;
    bit   rand_enp   = 1'b0;
    bit   raise_next = 1'b0;
    logic prev_enp   = 1'b0;

    host_vec_t hv [5];
    host_vec_t fresh;

    // Transaction-level reference model for the random phase.
    logic [11:0] mq [$];
    logic        m_on, m_host, m_rw, m_ack, m_ovf;
    logic [3:0]  m_a;
    logic [7:0]  m_d, m_rdata;
`ifdef POKEY_SCHED_RR_EN
    logic        m_last_host;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample after the edge, then act as the host requester and schedule enp.
    task automatic tick();
        prev_enp = enp;
        @(posedge clk);
        #1;
        if (raise_next) begin
            rif.h_req  = 1'b1;
            raise_next = 1'b0;
        end
        if (rif.h_ack && rif.h_req) begin
            rif.h_req = 1'b0;
            if (rearm > 0) begin
                rearm--;
                raise_next = 1'b1;
            end
        end
        phase = (phase + 1) % ENP_PER;
        enp   = rand_enp ? ($urandom_range(2, 0) == 0) : (enp_en && phase == 0);
    endtask

    task automatic push_entry(input logic [3:0] a, input logic [7:0] d);
        rif.p_push = 1'b1;
        rif.p_addr = a;
        rif.p_data = d;
        tick();
        rif.p_push = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((busy || rif.h_req || rif.h_ack || raise_next) && t < 10 * ENP_PER) begin
            tick();
            t++;
        end
        check("drain to idle", 32'({busy, rif.h_req, rif.h_ack}), 32'(0));
    endtask

    task automatic host_access(input host_vec_t v, input string tag);
        int t = 0;
        bit ack_early = 1'b0;
        bus_din = v.din;
        while (phase != ENP_PER - 3 && t < 2 * ENP_PER) begin
            tick();
            t++;
        end
        rif.h_rw    = v.rw;
        rif.h_addr  = v.addr;
        rif.h_wdata = v.wdata;
        rif.h_req   = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
            if (rif.h_ack) ack_early = 1'b1;
        end while (!busy && t < 4 * ENP_PER);
        check({tag, " grant latency"}, 32'(t), 32'(4));
        t = 0;
        while (busy && t < 4 * ENP_PER) begin
            check({tag, " bus fields"}, 32'({bus_cs, bus_rw, bus_a, bus_oe}),
                  32'({2'b10, v.rw, v.addr, v.exp_oe}));
            if (!v.rw) check({tag, " bus_dout"}, 32'(bus_dout), 32'(v.wdata));
            if (rif.h_ack) ack_early = 1'b1;
            tick();
            t++;
        end
        check({tag, " access length"}, 32'(t), 32'(ENP_PER));
        check({tag, " ack before completion"}, 32'(ack_early), 32'(0));
        check({tag, " ack/rdata at completion"}, 32'({rif.h_ack, rif.h_rdata}), 32'({1'b1, v.exp_rdata}));
        tick();
        check({tag, " ack one cycle, rdata held"}, 32'({rif.h_ack, rif.h_rdata, bus_oe, busy}),
              32'({1'b0, v.exp_rdata, 2'b00}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   t, got, pidx, n_exp;
        logic [7:0] order, exp_order;
        bit   bad;
        logic c_enp, c_req, c_rw, c_push, full_pre, host_done, hp, pp, take_host;
        logic [3:0] c_addr, c_paddr;
        logic [7:0] c_wdata, c_pdata, c_din;

        rif.h_req = 1'b0; rif.h_rw = 1'b0; rif.h_addr = '0; rif.h_wdata = '0;
        rif.p_push = 1'b0; rif.p_addr = '0; rif.p_data = '0;

        hv[0] = '{rw: 1'b0, addr: 4'h8, wdata: 8'h50, din: 8'h00, exp_oe: 1'b1, exp_rdata: 8'h00};
        hv[1] = '{rw: 1'b1, addr: 4'hA, wdata: 8'h00, din: 8'h3C, exp_oe: 1'b0, exp_rdata: 8'h3C};
        hv[2] = '{rw: 1'b0, addr: 4'hF, wdata: 8'hFF, din: 8'h99, exp_oe: 1'b1, exp_rdata: 8'h3C};
        hv[3] = '{rw: 1'b1, addr: 4'h0, wdata: 8'h11, din: 8'hA5, exp_oe: 1'b0, exp_rdata: 8'hA5};
        hv[4] = '{rw: 1'b0, addr: 4'h3, wdata: 8'h00, din: 8'h12, exp_oe: 1'b1, exp_rdata: 8'hA5};
        fresh = '{rw: 1'b0, addr: 4'h6, wdata: 8'h9E, din: 8'h00, exp_oe: 1'b1, exp_rdata: 8'h00};

        // Reset values, then a long idle stretch with enp running.
        tick();
        tick();
        check("reset bus", 32'({bus_cs, bus_rw, bus_a, bus_dout, bus_oe}), 32'({2'b01, 1'b1, 12'h000, 1'b0}));
        check("reset ack/rdata", 32'({rif.h_ack, rif.h_rdata}), 32'(0));
        check("reset full/ovf/busy", 32'({rif.p_full, rif.p_ovf, busy}), 32'(0));
        reset  = 1'b0;
        enp_en = 1'b1;
        for (int i = 0; i < 20 * ENP_PER; i++) begin
            tick();
            check("idle", 32'({bus_cs, bus_oe, rif.h_ack, busy}), 32'({2'b01, 3'b000}));
        end

        for (int i = 0; i < 5; i++) host_access(hv[i], $sformatf("host vec %0d", i));

        // Fill the FIFO with enp stopped, overflow once, then drain in push order.
        enp_en = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            push_entry(4'(i + 1), 8'(8'hC0 + i));
            check($sformatf("fifo push %0d full/ovf", i), 32'({rif.p_full, rif.p_ovf}),
                  32'({i >= 3, i >= 4}));
        end
        check("fifo no access without enp", 32'(busy), 32'(0));
        enp_en = 1'b1;
        got = 0;
        t   = 0;
        while (got < 4 && t < 8 * ENP_PER) begin
            tick();
            t++;
            if (prev_enp && busy) begin
                check($sformatf("fifo access %0d", got), 32'({bus_rw, bus_a, bus_dout, bus_oe}),
                      32'({1'b0, 4'(got + 1), 8'(8'hC0 + got), 1'b1}));
                check($sformatf("fifo full at access %0d", got), 32'(rif.p_full), 32'(got == 0));
                got++;
            end
        end
        check("fifo access count", 32'(got), 32'(4));
        drain();
        bad = 1'b0;
        for (int i = 0; i < 2 * ENP_PER; i++) begin
            tick();
            if (busy || rif.h_ack) bad = 1'b1;
        end
        check("fifo dropped entry not issued", 32'({bad, rif.p_ovf}), 32'({1'b0, 1'b1}));

        // Host and three player entries pending together.
        enp_en = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push_entry(4'(i + 1), 8'(8'hD0 + i));
        rif.h_rw = 1'b0; rif.h_addr = 4'hC; rif.h_wdata = 8'h77; rif.h_req = 1'b1;
`ifdef POKEY_SCHED_RR_EN
        rearm = 1; n_exp = 5; exp_order = 8'b0000_0101;
`else
        rearm = 0; n_exp = 4; exp_order = 8'b0000_0001;
`endif
        enp_en = 1'b1;
        got = 0; pidx = 0; t = 0; order = '0;
        while (got < n_exp && t < 10 * ENP_PER) begin
            tick();
            t++;
            if (prev_enp && busy) begin
                if (bus_a == 4'hC) begin
                    order[got] = 1'b1;
                    check("contention host data", 32'(bus_dout), 32'(8'h77));
                end else begin
                    check("contention player entry", 32'({bus_a, bus_dout}), 32'({4'(pidx + 1), 8'(8'hD0 + pidx)}));
                    pidx++;
                end
                got++;
            end
        end
        check("contention access count", 32'(got), 32'(n_exp));
        check("contention order", 32'(order), 32'(exp_order));
        drain();

        // Reset one cycle after a grant, with player entries still queued.
        enp_en = 1'b0;
        tick();
        push_entry(4'h1, 8'hE1);
        push_entry(4'h2, 8'hE2);
        rif.h_rw = 1'b0; rif.h_addr = 4'h9; rif.h_wdata = 8'h42; rif.h_req = 1'b1;
        enp_en = 1'b1;
        t = 0;
        while (!busy && t < 3 * ENP_PER) begin
            tick();
            t++;
        end
        check("midreset grant seen", 32'({busy, bus_a}), 32'({1'b1, 4'h9}));
        reset     = 1'b1;
        rif.h_req = 1'b0;
        tick();
        check("midreset bus", 32'({bus_cs, bus_oe, busy, rif.h_ack}), 32'({2'b01, 3'b000}));
        check("midreset fifo/ovf", 32'({rif.p_full, rif.p_ovf}), 32'(0));
        reset = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 3 * ENP_PER; i++) begin
            tick();
            if (busy || rif.h_ack) bad = 1'b1;
        end
        check("midreset quiet afterwards", 32'(bad), 32'(0));
        host_access(fresh, "post-reset host");

        // Random traffic with random enp against the reference model.
        reset = 1'b1; rif.h_req = 1'b0; rif.p_push = 1'b0; rearm = 0;
        tick();
        reset = 1'b0; enp_en = 1'b0; rand_enp = 1'b1;
        mq.delete();
        m_on = 0; m_host = 0; m_rw = 0; m_ack = 0; m_ovf = 0; m_a = '0; m_d = '0; m_rdata = '0;
`ifdef POKEY_SCHED_RR_EN
        m_last_host = 1'b0;
`endif
        for (int it = 0; it < 2000; it++) begin
            bus_din    = 8'($urandom);
            rif.p_push = ($urandom_range((it < 1000) ? 1 : 5, 0) == 0);
            rif.p_addr = 4'($urandom);
            rif.p_data = 8'($urandom);
            if (!rif.h_req && !rif.h_ack && $urandom_range(5, 0) == 0) begin
                rif.h_rw    = 1'($urandom);
                rif.h_addr  = 4'($urandom);
                rif.h_wdata = 8'($urandom);
                rif.h_req   = 1'b1;
            end
            c_enp = enp; c_req = rif.h_req; c_rw = rif.h_rw; c_addr = rif.h_addr; c_wdata = rif.h_wdata;
            c_push = rif.p_push; c_paddr = rif.p_addr; c_pdata = rif.p_data; c_din = bus_din;
            tick();

            full_pre  = (mq.size() == DEPTH);
            host_done = 1'b0;
            m_ack     = 1'b0;
            if (c_enp && m_on) begin
                if (m_host) begin
                    m_ack     = 1'b1;
                    host_done = 1'b1;
                    if (m_rw) m_rdata = c_din;
                end else begin
                    void'(mq.pop_front());
                end
                m_on = 1'b0;
            end
            if (c_enp) begin
                hp = c_req && !host_done;
                pp = (mq.size() != 0);
`ifdef POKEY_SCHED_RR_EN
                take_host = hp && (!pp || !m_last_host);
`else
                take_host = hp;
`endif
                if (take_host) begin
                    m_on = 1'b1; m_host = 1'b1; m_rw = c_rw; m_a = c_addr; m_d = c_wdata;
                end else if (pp) begin
                    m_on = 1'b1; m_host = 1'b0; m_rw = 1'b0; {m_a, m_d} = mq[0];
                end
`ifdef POKEY_SCHED_RR_EN
                if (m_on) m_last_host = m_host;
`endif
            end
            if (c_push) begin
                if (full_pre) m_ovf = 1'b1;
                else mq.push_back({c_paddr, c_pdata});
            end

            check("rand busy/cs", 32'({busy, bus_cs}), 32'({m_on, m_on ? 2'b10 : 2'b01}));
            if (m_on) check("rand access", 32'({bus_rw, bus_a, bus_oe}), 32'({m_rw, m_a, !m_rw}));
            if (m_on && !m_rw) check("rand wdata", 32'(bus_dout), 32'(m_d));
            check("rand ack/rdata", 32'({rif.h_ack, rif.h_rdata}), 32'({m_ack, m_rdata}));
            check("rand full/ovf", 32'({rif.p_full, rif.p_ovf}), 32'({mq.size() == DEPTH, m_ovf}));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
